// File: rtl/sram_arbiter.sv
// Shares one external SRAM between the CPU (fixed priority) and a DMA requester.
// Define SRAM_ARB_STARVE_GUARD_EN to bound DMA waiting by stalling the CPU via cpu_rdy.
module sram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rdy,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dout,
  output logic          sram_oe,
  input  logic [DW-1:0] sram_din
);

  typedef enum logic [1:0] {IDLE, CPU, DMA_WR, DMA_RD} state_t;

  state_t        state, state_next;
  logic          dma_grant, cpu_grant, guard_trip;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] dout_next;
  logic          oe_next;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  logic [3:0] wait_cnt;

  // Counts consecutive denied DMA cycles; reaching STARVE_MAX forces one DMA slot.
  assign guard_trip = !reset && dma_req && (wait_cnt == 4'(STARVE_MAX));
  assign cpu_rdy    = !guard_trip;

  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if (dma_req && !dma_grant)
      wait_cnt <= wait_cnt + 4'd1;
    else
      wait_cnt <= '0;
  end
`else
  assign guard_trip = 1'b0;
  assign cpu_rdy    = 1'b1;
`endif

  always_comb begin
    dma_grant  = 1'b0;
    cpu_grant  = 1'b0;
    state_next = IDLE;
    addr_next  = sram_addr;
    dout_next  = sram_dout;
    oe_next    = 1'b0;
    // No grants while in reset, so a pending DMA request is re-arbitrated afterwards.
    if (!reset) begin
      dma_grant = dma_req && (!cpu_req || guard_trip);
      cpu_grant = cpu_req && !dma_grant;
    end
    if (dma_grant) begin
      state_next = dma_we ? DMA_WR : DMA_RD;
      addr_next  = dma_addr;
      dout_next  = dma_wdata;
      oe_next    = dma_we;
    end else if (cpu_grant) begin
      state_next = CPU;
      addr_next  = cpu_addr;
      dout_next  = cpu_wdata;
      oe_next    = cpu_we;
    end
  end

  assign dma_ack   = dma_grant;
  assign cpu_rdata = sram_din;

  // State names the owner of the access currently on the SRAM pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_oe    <= 1'b0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
    end else begin
      state      <= state_next;
      sram_addr  <= addr_next;
      sram_dout  <= dout_next;
      sram_oe    <= oe_next;
      dma_rvalid <= (state == DMA_RD);
      if (state == DMA_RD)
        dma_rdata <= sram_din;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter with a behavioural SRAM and reference memory.
// Follows SRAM_ARB_STARVE_GUARD_EN so the reference matches whichever build is compiled.
module tb_sram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int STARVE_MAX = 4;
`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          cpu_rdy, dma_ack, dma_rvalid;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic          sram_oe;
  logic [DW-1:0] sram_din;

  sram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_oe(sram_oe), .sram_din(sram_din)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM part on the pins, plus the reference memory updated at grant time.
  logic [DW-1:0] sram_mem [0:65535];
  logic [DW-1:0] ref_mem  [0:65535];
  assign sram_din = sram_mem[sram_addr];
  always @(posedge clk) if (sram_oe === 1'b1) sram_mem[sram_addr] <= sram_dout;

  typedef struct { int due; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  wr_t wr_q[$];
  rd_t cpu_q[$];
  rd_t dma_q[$];

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int streak = 0;
  bit mon_en = 1'b0;
  bit prev_reset = 1'b0;
  bit last_ack = 1'b0;
  bit last_rdy = 1'b1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask

  task automatic report_missing(input string name, input int due);
    total++;
    bad++;
    $display("[TB] FAIL %s cycle=%0d got=none expected_at_cycle=%0d", name, cycle, due);
  endtask

  // Reference arbitration: CPU first unless the DMA has waited STARVE_MAX cycles (guard builds).
  task automatic model_cycle();
    bit trip, dwin, cwin;
    if (prev_reset) begin
      check_output("rst_sram_oe", sram_oe, 0);
      check_output("rst_sram_addr", sram_addr, 0);
      check_output("rst_sram_dout", sram_dout, 0);
      check_output("rst_dma_rvalid", dma_rvalid, 0);
      check_output("rst_dma_rdata", dma_rdata, 0);
    end
    prev_reset = reset;
    if (reset) begin
      check_output("rst_dma_ack", dma_ack, 0);
      check_output("rst_cpu_rdy", cpu_rdy, 1);
      streak = 0;
      dma_q = dma_q.find(x) with (x.due != cycle + 1);
      last_ack = 1'b0;
      last_rdy = 1'b1;
      return;
    end
    trip = GUARD && dma_req && (streak == STARVE_MAX);
    dwin = dma_req && (!cpu_req || trip);
    cwin = cpu_req && !dwin;
    streak = (dma_req && !dwin) ? streak + 1 : 0;
    check_output("dma_ack", dma_ack, dwin);
    check_output("cpu_rdy", cpu_rdy, !trip);
    last_ack = dwin;
    last_rdy = !trip;
    if (dwin) begin
      if (dma_we) begin
        wr_q.push_back('{cycle + 1, dma_addr, dma_wdata});
        ref_mem[dma_addr] = dma_wdata;
      end else
        dma_q.push_back('{cycle + 2, ref_mem[dma_addr]});
    end else if (cwin) begin
      if (cpu_we) begin
        wr_q.push_back('{cycle + 1, cpu_addr, cpu_wdata});
        ref_mem[cpu_addr] = cpu_wdata;
      end else
        cpu_q.push_back('{cycle + 1, ref_mem[cpu_addr]});
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit cr, input bit cw, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cd, input bit dr, input bit dw,
                                input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(posedge clk);
    #1;
    reset = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    @(negedge clk);
    model_cycle();
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a write strobe, rvalid, or CPU read slot.
  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    if (mon_en) begin
      while (wr_q.size() != 0 && wr_q[0].due < cycle) begin
        w = wr_q.pop_front();
        report_missing("write_missing", w.due);
      end
      while (dma_q.size() != 0 && dma_q[0].due < cycle) begin
        r = dma_q.pop_front();
        report_missing("rvalid_missing", r.due);
      end
      if (sram_oe !== 1'b0) begin
        if (wr_q.size() != 0 && wr_q[0].due == cycle) begin
          w = wr_q.pop_front();
          check_output("write_addr", sram_addr, w.addr);
          check_output("write_data", sram_dout, w.data);
        end else
          check_output("unexpected_write", sram_oe, 0);
      end
      if (dma_rvalid !== 1'b0) begin
        if (dma_q.size() != 0 && dma_q[0].due == cycle) begin
          r = dma_q.pop_front();
          check_output("dma_rdata", dma_rdata, r.data);
        end else
          check_output("unexpected_rvalid", dma_rvalid, 0);
      end
      if (cpu_q.size() != 0 && cpu_q[0].due == cycle) begin
        r = cpu_q.pop_front();
        check_output("cpu_rdata", cpu_rdata, r.data);
      end
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] base;
    base = ($urandom_range(0, 1) != 0) ? 16'h3000 : 16'h0000;
    return base | AW'($urandom_range(0, 15));
  endfunction

  initial begin
    bit r, ncr, ncw, ndr, ndw;
    logic [AW-1:0] nca, nda;
    logic [DW-1:0] ncd, ndd;
    int cpu_bias;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = 8'($urandom);
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[16'h3010] = 8'h5C;
    ref_mem[16'h3010]  = 8'h5C;

    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // CPU write then read back of 0x0123
    apply_stimulus(0, 1, 1, 16'h0123, 8'hA5, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 16'h0123, 8'h00, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // DMA read of 0x3010 with the CPU idle
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 16'h3010, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Simultaneous requests: CPU writes twice, DMA write held until the CPU lets go
    apply_stimulus(0, 1, 1, 16'h0010, 8'h11, 1, 1, 16'h3020, 8'h77);
    apply_stimulus(0, 1, 1, 16'h0011, 8'h22, 1, 1, 16'h3020, 8'h77);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 16'h3020, 8'h77);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back DMA writes 0x0000..0x0003
    for (int i = 0; i < 4; i++)
      apply_stimulus(0, 0, 0, 0, 0, 1, 1, AW'(i), 8'(8'hC0 + i));
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // CPU and DMA both held busy: guard forces a DMA slot every STARVE_MAX+1 cycles
    for (int i = 0; i < 15; i++)
      apply_stimulus(0, 1, 0, 16'h0002, 0, 1, 0, 16'h0001, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 16'h0001, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the cycle after a DMA read grant discards that read
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 16'h3010, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    ncr = 0; ncw = 0; nca = '0; ncd = '0; ndr = 0; ndw = 0; nda = '0; ndd = '0;
    for (int i = 0; i < 3000; i++) begin
      cpu_bias = ((i / 400) % 2 == 0) ? 4 : 9;
      r = ($urandom_range(0, 99) == 0);
      if (!(ndr && !last_ack)) begin
        ndr = ($urandom_range(0, 2) != 0);
        ndw = ($urandom_range(0, 1) != 0);
        nda = rand_addr();
        ndd = 8'($urandom);
      end
      if (!(ncr && !last_rdy)) begin
        ncr = ($urandom_range(0, 9) < cpu_bias);
        ncw = ($urandom_range(0, 1) != 0);
        nca = rand_addr();
        ncd = 8'($urandom);
      end
      apply_stimulus(r, ncr, ncw, nca, ncd, ndr, ndw, nda, ndd);
    end

    for (int i = 0; i < 6; i++)
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    while (wr_q.size() != 0) report_missing("write_left", wr_q.pop_front().due);
    while (dma_q.size() != 0) report_missing("rvalid_left", dma_q.pop_front().due);
    while (cpu_q.size() != 0) report_missing("cpu_read_left", cpu_q.pop_front().due);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
